rook_move_checker: RTL and testbench
====================================

Name: rook_move_checker

Overview:
- Reader-side client of the 64-square board RAM (64 x PIECE_W, 1-cycle registered read).
- On `start`, decides whether a rook move from `from_sq` to `to_sq` is legal on the current board.
- Walks the path one square per RAM read and returns a single `legal` verdict with a `done` pulse.
- Sits between the move-input logic and the board RAM; it only reads and never writes the board.

Parameters:
- PIECE_W, 6: width of a piece code. 0 = empty, 1–16 = white, 17–32 = black.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  request pulse; sampled only when busy=0
- from_sq  in  6  source square; index = rank*8 + file, 0 = a1, 63 = h8
- to_sq  in  6  destination square, same encoding
- busy  out  1  check in progress
- done  out  1  one-cycle pulse; legal valid this cycle
- legal  out  1  verdict; held until the next accepted start
- mem_en  out  1  RAM enable
- mem_rw  out  1  RAM write select; tied 0 (read only)
- mem_addr  out  6  RAM address
- mem_rdata  in  PIECE_W  RAM data_out; valid the cycle after mem_en=1

Behaviour:
- Reset values: state IDLE, busy=0, done=0, legal=0, mem_en=0, mem_addr=0, internal from/to/cur/step regs = 0.
- Reset mid-operation: immediate return to IDLE, no done pulse, legal cleared.
- FSM states: IDLE, RD_SRC, CHK_SRC, RD_PATH, CHK_PATH, RD_DST, CHK_DST, DONE.
- IDLE:
  - If start=1: latch from_sq and to_sq, go to RD_SRC, set busy=1 from the next cycle.
  - start while busy is ignored.
- RD_SRC: mem_en=1, mem_addr=from. Go to CHK_SRC.
- CHK_SRC: src = mem_rdata. Reject (legal=0, go to DONE) if any of:
  - src is not a rook code (13, 14, 29, 30);
  - from == to;
  - not same rank and not same file.
- Otherwise set step and cur = from + step:
  - step = +1 / -1 for same rank (to > from / to < from);
  - step = +8 / -8 for same file.
- If cur == to, go to RD_DST; else go to RD_PATH.
- RD_PATH: mem_en=1, mem_addr=cur. Go to CHK_PATH.
- CHK_PATH:
  - If mem_rdata != 0: legal=0, go to DONE.
  - Else cur += step (6-bit modulo). If cur == to go to RD_DST, else go to RD_PATH.
- RD_DST: mem_en=1, mem_addr=to. Go to CHK_DST.
- CHK_DST:
  - legal=1 if mem_rdata == 0, or mem_rdata has the opposite colour to src; else legal=0.
  - Go to DONE.
- DONE: done=1, busy=1. Next state IDLE; busy=0 the cycle after.
- mem_en is 1 only in the RD_* states. mem_addr holds its last value otherwise.
- Latency, counted from the start-sampling edge:
  - accept: done in cycle 5 + 2*(intermediate squares);
  - geometry or source reject: done in cycle 3;
  - blocked path: done at the first occupied square's CHK_PATH + 1.
- Wrap-around:
  - Same-rank and same-file are checked before stepping, so ±1 never crosses a rank edge.
  - ±8 never leaves 0..63.
- Colour is decided by code range: 1–16 white, 17–32 black. Codes >32 are treated as non-rook and rejected at source.

Optional Feature:
- Macro: QUEEN_SLIDE_EN.
- Defined: queen codes 15 and 31 are also accepted at CHK_SRC. Orthogonal queen moves then get the full path and destination check.
- Undefined: 15 and 31 are rejected like any non-rook piece.

Decomposition:
- Package chess_pkg holds:
  - PIECE_W and SQ_W = 6;
  - EMPTY = 0;
  - WHITE_MIN/MAX = 1/16 and BLACK_MIN/MAX = 17/32;
  - rook codes 13, 14, 29, 30 and queen codes 15, 31;
  - the FSM state enum;
  - an is_white / is_black colour function.
- No sub-module needed; single FSM module.

Test Plan:
- Initial board, a1(0) → a3(16): a2 (code 1) is read → legal=0, done in cycle 5, exactly one path read at addr 8.
- Board with a2..a6 empty, black pawn 17 on a7: a1(0) → a7(48) → legal=1, done in cycle 15, reads at 0, 8, 16, 24, 32, 40, 48.
- a1(0) → b2(9) diagonal → legal=0, done in cycle 3, single read at addr 0.
- from = e4(28), empty square → legal=0, done in cycle 3. Also from = to = 0 → legal=0.
- White rook on h1(7), white knight on g1(6), move h1 → g1 → legal=0 at CHK_DST. Same move with black code 25 on g1 → legal=1.
- Reset asserted in RD_PATH of a long scan → next cycle busy=0, mem_en=0, no done. A new start afterwards completes normally.
- Queen 15 on d1(3), d2..d7 empty, d1 → d8: QUEEN_SLIDE_EN defined → legal per path; undefined → legal=0 in cycle 3.

Source files
------------

// File: rtl/rook_move_checker_pkg.sv
// Shared chess types for the board-RAM clients: piece codes, square width,
// FSM states and colour helpers.
// Optional feature macro: QUEEN_SLIDE_EN (queens may slide orthogonally like rooks).
package chess_pkg;

    localparam int PIECE_W = 6;
    localparam int SQ_W    = 6;

    localparam logic [PIECE_W-1:0] EMPTY     = 6'd0;
    localparam logic [PIECE_W-1:0] WHITE_MIN = 6'd1;
    localparam logic [PIECE_W-1:0] WHITE_MAX = 6'd16;
    localparam logic [PIECE_W-1:0] BLACK_MIN = 6'd17;
    localparam logic [PIECE_W-1:0] BLACK_MAX = 6'd32;

    localparam logic [PIECE_W-1:0] W_ROOK_A = 6'd13;
    localparam logic [PIECE_W-1:0] W_ROOK_B = 6'd14;
    localparam logic [PIECE_W-1:0] B_ROOK_A = 6'd29;
    localparam logic [PIECE_W-1:0] B_ROOK_B = 6'd30;
    localparam logic [PIECE_W-1:0] W_QUEEN  = 6'd15;
    localparam logic [PIECE_W-1:0] B_QUEEN  = 6'd31;

    typedef enum logic [2:0] {
        IDLE, RD_SRC, CHK_SRC, RD_PATH, CHK_PATH, RD_DST, CHK_DST, DONE
    } state_t;

    function automatic logic is_white(input logic [PIECE_W-1:0] c);
        return (c >= WHITE_MIN) && (c <= WHITE_MAX);
    endfunction

    function automatic logic is_black(input logic [PIECE_W-1:0] c);
        return (c >= BLACK_MIN) && (c <= BLACK_MAX);
    endfunction

    // Pieces allowed to make an orthogonal sliding move.
    function automatic logic is_slider(input logic [PIECE_W-1:0] c);
        logic r;
        r = (c == W_ROOK_A) || (c == W_ROOK_B) || (c == B_ROOK_A) || (c == B_ROOK_B);
`ifdef QUEEN_SLIDE_EN
        r = r || (c == W_QUEEN) || (c == B_QUEEN);
`endif
        return r;
    endfunction

endpackage

// File: rtl/rook_move_checker_if.sv
// Request/verdict and board-RAM read signals of the rook move checker.
// slave: the checker (takes requests, drives RAM address); master: requester side + RAM.
// Ports: start/from_sq/to_sq in, busy/done/legal out, mem_en/mem_rw/mem_addr out, mem_rdata in.
interface rook_move_checker_if import chess_pkg::*; ();

    logic               start;
    logic [SQ_W-1:0]    from_sq;
    logic [SQ_W-1:0]    to_sq;
    logic               busy;
    logic               done;
    logic               legal;
    logic               mem_en;
    logic               mem_rw;
    logic [SQ_W-1:0]    mem_addr;
    logic [PIECE_W-1:0] mem_rdata;

    modport slave (
        input  start, from_sq, to_sq, mem_rdata,
        output busy, done, legal, mem_en, mem_rw, mem_addr
    );

    modport master (
        output start, from_sq, to_sq, mem_rdata,
        input  busy, done, legal, mem_en, mem_rw, mem_addr
    );

endinterface

// File: rtl/rook_move_checker.sv
// Checks legality of a rook move by walking the path through the board RAM, one square per read.
// Latency: reject at source 3 cycles, accept 5 + 2*(intermediate squares), blocked at first occupied square.
// Backpressure: start is ignored while busy; read-only RAM client (mem_rw tied 0). Macro: QUEEN_SLIDE_EN.
// Ports: clk, reset (sync, active-high), bus (rook_move_checker_if.slave).
module rook_move_checker import chess_pkg::*; (
    input  logic                clk,
    input  logic                reset,
    rook_move_checker_if.slave  bus
);

    state_t               state_q, state_n;
    logic [SQ_W-1:0]      from_q, from_n;
    logic [SQ_W-1:0]      to_q, to_n;
    logic [SQ_W-1:0]      cur_q, cur_n;
    logic [SQ_W-1:0]      step_q, step_n;
    logic [SQ_W-1:0]      addr_q, addr_n;
    logic [PIECE_W-1:0]   src_q, src_n;
    logic                 legal_q, legal_n;

    logic                 same_rank, same_file;
    logic [SQ_W-1:0]      step_v, cur_v;

    assign same_rank = (from_q[5:3] == to_q[5:3]);
    assign same_file = (from_q[2:0] == to_q[2:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            from_q  <= '0;
            to_q    <= '0;
            cur_q   <= '0;
            step_q  <= '0;
            addr_q  <= '0;
            src_q   <= '0;
            legal_q <= 1'b0;
        end else begin
            state_q <= state_n;
            from_q  <= from_n;
            to_q    <= to_n;
            cur_q   <= cur_n;
            step_q  <= step_n;
            addr_q  <= addr_n;
            src_q   <= src_n;
            legal_q <= legal_n;
        end
    end

    always_comb begin
        state_n = state_q;
        from_n  = from_q;
        to_n    = to_q;
        cur_n   = cur_q;
        step_n  = step_q;
        addr_n  = addr_q;
        src_n   = src_q;
        legal_n = legal_q;
        step_v  = '0;
        cur_v   = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    from_n  = bus.from_sq;
                    to_n    = bus.to_sq;
                    addr_n  = bus.from_sq;
                    legal_n = 1'b0;
                    state_n = RD_SRC;
                end
            end
            RD_SRC:  state_n = CHK_SRC;
            CHK_SRC: begin
                src_n = bus.mem_rdata;
                if (!is_slider(bus.mem_rdata) || (from_q == to_q) || (!same_rank && !same_file)) begin
                    legal_n = 1'b0;
                    state_n = DONE;
                end else begin
                    // Negative steps are stored as 6-bit two's complement (-1 = 63, -8 = 56).
                    if (same_rank) step_v = (to_q > from_q) ? 6'd1 : 6'd63;
                    else           step_v = (to_q > from_q) ? 6'd8 : 6'd56;
                    cur_v  = from_q + step_v;
                    step_n = step_v;
                    cur_n  = cur_v;
                    if (cur_v == to_q) begin
                        addr_n  = to_q;
                        state_n = RD_DST;
                    end else begin
                        addr_n  = cur_v;
                        state_n = RD_PATH;
                    end
                end
            end
            RD_PATH: state_n = CHK_PATH;
            CHK_PATH: begin
                if (bus.mem_rdata != EMPTY) begin
                    legal_n = 1'b0;
                    state_n = DONE;
                end else begin
                    cur_v = cur_q + step_q;
                    cur_n = cur_v;
                    if (cur_v == to_q) begin
                        addr_n  = to_q;
                        state_n = RD_DST;
                    end else begin
                        addr_n  = cur_v;
                        state_n = RD_PATH;
                    end
                end
            end
            RD_DST:  state_n = CHK_DST;
            CHK_DST: begin
                legal_n = (bus.mem_rdata == EMPTY)
                       || (is_white(src_q) && is_black(bus.mem_rdata))
                       || (is_black(src_q) && is_white(bus.mem_rdata));
                state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.legal    = legal_q;
    assign bus.mem_en   = (state_q == RD_SRC) || (state_q == RD_PATH) || (state_q == RD_DST);
    assign bus.mem_rw   = 1'b0;
    assign bus.mem_addr = addr_q;

endmodule

// File: tb/tb_rook_move_checker.sv
// Directed bench for rook_move_checker with a registered-read board RAM model.
// Expected verdict/latency and RAM read addresses are queued at stimulus time and
// popped when the DUT reads the RAM or pulses done.
module tb_rook_move_checker;
    import chess_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic legal;
        int   lat;
        int   t0;
    } exp_t;

    exp_t               exp_q[$];
    logic [SQ_W-1:0]    rd_q[$];
    logic [PIECE_W-1:0] board[64];
    logic [PIECE_W-1:0] rdata_q = '0;

    rook_move_checker_if bus();

    rook_move_checker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Board RAM: 1-cycle registered read.
    always @(posedge clk) if (bus.mem_en) rdata_q <= board[bus.mem_addr];
    assign bus.mem_rdata = rdata_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every RAM read and every done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_en) begin
                logic [SQ_W-1:0] ea;
                ea = (rd_q.size() != 0) ? rd_q.pop_front() : 'x;
                chk("mem_addr", {26'd0, bus.mem_addr}, {26'd0, ea});
                chk("mem_rw", {31'd0, bus.mem_rw}, 32'd0);
            end
            if (bus.done) begin
                exp_t e;
                if (exp_q.size() != 0) e = exp_q.pop_front();
                else begin e.legal = 1'bx; e.lat = -1; e.t0 = cyc; end
                chk("legal", {31'd0, bus.legal}, {31'd0, e.legal});
                chk("latency", cyc - e.t0 + 1, e.lat);
            end
        end
    end

    // Expected read sequence: source, then each path square until blocked, then destination.
    task automatic push_reads(input logic [SQ_W-1:0] f, input logic [SQ_W-1:0] t);
        logic [SQ_W-1:0] sq, st;
        rd_q.push_back(f);
        if (!is_slider(board[f]) || f == t || (f[5:3] != t[5:3] && f[2:0] != t[2:0])) return;
        if (f[5:3] == t[5:3]) st = (t > f) ? 6'd1 : 6'd63;
        else                  st = (t > f) ? 6'd8 : 6'd56;
        sq = f + st;
        while (sq != t) begin
            rd_q.push_back(sq);
            if (board[sq] != EMPTY) return;
            sq = sq + st;
        end
        rd_q.push_back(t);
    endtask

    task automatic launch(input logic [SQ_W-1:0] f, input logic [SQ_W-1:0] t,
                          input logic el, input int elat);
        exp_t e;
        @(negedge clk);
        push_reads(f, t);
        e.legal = el; e.lat = elat; e.t0 = cyc + 1;
        exp_q.push_back(e);
        bus.start = 1'b1; bus.from_sq = f; bus.to_sq = t;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_move(input logic [SQ_W-1:0] f, input logic [SQ_W-1:0] t,
                            input logic el, input int elat);
        bit ok;
        launch(f, t, el, elat);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (exp_q.size() == 0) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL timeout from=%0d to=%0d", f, t);
            exp_q.delete(); rd_q.delete();
        end
        @(negedge clk);
        chk("busy_after", {31'd0, bus.busy}, 32'd0);
        chk("legal_held", {31'd0, bus.legal}, {31'd0, el});
        chk("reads_left", rd_q.size(), 0);
        rd_q.delete();
    endtask

    task automatic init_board();
        logic [PIECE_W-1:0] back_w[8];
        logic [PIECE_W-1:0] back_b[8];
        back_w = '{6'd13, 6'd9, 6'd11, 6'd15, 6'd16, 6'd12, 6'd10, 6'd14};
        back_b = '{6'd29, 6'd25, 6'd27, 6'd31, 6'd32, 6'd28, 6'd26, 6'd30};
        for (int i = 0; i < 64; i++) board[i] = EMPTY;
        for (int i = 0; i < 8; i++) begin
            board[i]      = back_w[i];
            board[8 + i]  = 6'(1 + i);
            board[48 + i] = 6'(17 + i);
            board[56 + i] = back_b[i];
        end
    endtask

    initial begin
        bit hit;
        bus.start = 1'b0; bus.from_sq = '0; bus.to_sq = '0;
        init_board();
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_legal", {31'd0, bus.legal}, 32'd0);
        chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("rst_mem_addr", {26'd0, bus.mem_addr}, 32'd0);
        chk("rst_mem_rw", {31'd0, bus.mem_rw}, 32'd0);
        reset = 1'b0;

        // a1 -> a3 blocked by the a2 pawn.
        run_move(6'd0, 6'd16, 1'b0, 5);
        // Open the a-file up to the black pawn on a7 and capture it.
        for (int s = 8; s <= 40; s += 8) board[s] = EMPTY;
        run_move(6'd0, 6'd48, 1'b1, 15);
        // Diagonal, empty source, null move.
        run_move(6'd0, 6'd9, 1'b0, 3);
        run_move(6'd28, 6'd30, 1'b0, 3);
        run_move(6'd0, 6'd0, 1'b0, 3);
        // h1 -> g1: own knight, then a black piece.
        run_move(6'd7, 6'd6, 1'b0, 5);
        board[6] = 6'd25;
        run_move(6'd7, 6'd6, 1'b1, 5);
        // Black rook h8 -> h3 down an opened h-file.
        board[55] = EMPTY;
        run_move(6'd63, 6'd23, 1'b1, 13);

        // Reset in the middle of an a-file scan.
        launch(6'd0, 6'd48, 1'b1, 15);
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.mem_en && bus.mem_addr == 6'd16) begin hit = 1; break; end
            @(negedge clk);
        end
        chk("scan_reached", {31'd0, hit}, 32'd1);
        #1;
        exp_q.delete(); rd_q.delete();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
        chk("mid_rst_legal", {31'd0, bus.legal}, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        run_move(6'd0, 6'd48, 1'b1, 15);

        // Queen d1 -> d8 along a cleared d-file, capturing the black queen.
        board[3] = W_QUEEN;
        for (int s = 11; s <= 51; s += 8) board[s] = EMPTY;
`ifdef QUEEN_SLIDE_EN
        run_move(6'd3, 6'd59, 1'b1, 17);
`else
        run_move(6'd3, 6'd59, 1'b0, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
